// File: rtl/gpu_line_sequencer.sv
// gpu_line_sequencer
// Round-robin front end for the Bresenham line engine. Two requesters compete
// for a single command slot; the winning command is held on the engine
// endpoint/colour outputs, engine start is driven as a level, and every
// pixel the engine reports while busy is forwarded as a framebuffer write.
// A watchdog bounds the time spent waiting on the engine.
module gpu_line_sequencer #(
    parameter  int WIDTH_BITS   = 10,
    parameter  int HEIGHT_BITS  = 9,
    parameter  int CHANNEL_BITS = 8,
    parameter  int TIMEOUT      = 2048,
    localparam int CMD_W        = 2*WIDTH_BITS + 2*HEIGHT_BITS + 3*CHANNEL_BITS
) (
    input  logic                    clk,
    input  logic                    n_rst,
    // requester 0: host command path
    input  logic                    req0_valid,
    output logic                    req0_ready,
    input  logic [CMD_W-1:0]        req0_cmd,
    // requester 1: shape decomposer
    input  logic                    req1_valid,
    output logic                    req1_ready,
    input  logic [CMD_W-1:0]        req1_cmd,
    // line engine command side
    output logic [WIDTH_BITS-1:0]   le_x1,
    output logic [HEIGHT_BITS-1:0]  le_y1,
    output logic [WIDTH_BITS-1:0]   le_x2,
    output logic [HEIGHT_BITS-1:0]  le_y2,
    output logic [CHANNEL_BITS-1:0] le_r,
    output logic [CHANNEL_BITS-1:0] le_g,
    output logic [CHANNEL_BITS-1:0] le_b,
    output logic                    le_start,
    // line engine status side
    input  logic                    le_busy,
    input  logic                    le_done,
    input  logic [WIDTH_BITS-1:0]   le_x,
    input  logic [HEIGHT_BITS-1:0]  le_y,
    // framebuffer pixel stream
    output logic                    px_valid,
    output logic [WIDTH_BITS-1:0]   px_x,
    output logic [HEIGHT_BITS-1:0]  px_y,
    output logic [CHANNEL_BITS-1:0] px_r,
    output logic [CHANNEL_BITS-1:0] px_g,
    output logic [CHANNEL_BITS-1:0] px_b,
    // status
    output logic                    busy,
    output logic                    grant_id,
    output logic [15:0]             pix_count,
    output logic                    timeout_err
);

    // Field offsets inside a command word {x1,y1,x2,y2,r,g,b}, b in the LSBs.
    localparam int OFF_B  = 0;
    localparam int OFF_G  = OFF_B  + CHANNEL_BITS;
    localparam int OFF_R  = OFF_G  + CHANNEL_BITS;
    localparam int OFF_Y2 = OFF_R  + CHANNEL_BITS;
    localparam int OFF_X2 = OFF_Y2 + HEIGHT_BITS;
    localparam int OFF_Y1 = OFF_X2 + WIDTH_BITS;
    localparam int OFF_X1 = OFF_Y1 + HEIGHT_BITS;

    // Watchdog only ever needs to reach TIMEOUT-1.
    localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_DRAW   = 2'd2,
        S_GAP    = 2'd3
    } state_e;

    state_e            state_q,    state_d;
    logic [CMD_W-1:0]  cmd_q,      cmd_d;
    logic              le_start_q, le_start_d;
    logic              grant_q,    grant_d;
    logic              rr_last_q,  rr_last_d;
    logic [15:0]       pix_q,      pix_d;
    logic              tmo_q,      tmo_d;
    logic [WD_W-1:0]   wdog_q,     wdog_d;

    logic              want0, want1, accept;
    logic              engaged, wd_hit;

    // Arbitration: a lone requester wins outright; on contention the one that
    // did not win last time goes first. Ready is only offered while idle.
    assign want0      = req0_valid & (~req1_valid | rr_last_q);
    assign want1      = req1_valid & (~req0_valid | ~rr_last_q);
    assign req0_ready = (state_q == S_IDLE) & want0;
    assign req1_ready = (state_q == S_IDLE) & want1;
    assign accept     = req0_ready | req1_ready;

    // The watchdog fires in the cycle its count reaches TIMEOUT-1; that cycle
    // already suppresses start and pixel output so the abort is clean.
    assign engaged = (state_q == S_LAUNCH) | (state_q == S_DRAW);
    assign wd_hit  = engaged & (wdog_q == WD_LAST);

    assign le_start = le_start_q & ~wd_hit;
    assign px_valid = (state_q == S_DRAW) & le_busy & ~wd_hit;

    // Held command fields drive the engine and colour every pixel.
    assign le_x1 = cmd_q[OFF_X1 +: WIDTH_BITS];
    assign le_y1 = cmd_q[OFF_Y1 +: HEIGHT_BITS];
    assign le_x2 = cmd_q[OFF_X2 +: WIDTH_BITS];
    assign le_y2 = cmd_q[OFF_Y2 +: HEIGHT_BITS];
    assign le_r  = cmd_q[OFF_R  +: CHANNEL_BITS];
    assign le_g  = cmd_q[OFF_G  +: CHANNEL_BITS];
    assign le_b  = cmd_q[OFF_B  +: CHANNEL_BITS];

    assign px_x = le_x;
    assign px_y = le_y;
    assign px_r = le_r;
    assign px_g = le_g;
    assign px_b = le_b;

    assign busy        = (state_q != S_IDLE);
    assign grant_id    = grant_q;
    assign pix_count   = pix_q;
    assign timeout_err = tmo_q;

    // Next-state and register-update logic for the command sequencer.
    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        le_start_d = le_start_q;
        grant_d    = grant_q;
        rr_last_d  = rr_last_q;
        pix_d      = pix_q;
        tmo_d      = tmo_q;
        wdog_d     = wdog_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    cmd_d      = req1_ready ? req1_cmd : req0_cmd;
                    grant_d    = req1_ready;
                    rr_last_d  = req1_ready;
                    pix_d      = '0;
                    tmo_d      = 1'b0;
                    wdog_d     = '0;
                    le_start_d = 1'b1;
                    state_d    = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                // le_done may still be high from the previous line; only a
                // fresh busy means the engine has picked up this command.
                wdog_d = wdog_q + 1'b1;
                if (le_busy) begin
                    state_d = S_DRAW;
                end
            end
            S_DRAW: begin
                wdog_d = wdog_q + 1'b1;
                if (px_valid && (pix_q != 16'hFFFF)) begin
                    pix_d = pix_q + 16'd1;
                end
                if (le_done && !le_busy) begin
                    le_start_d = 1'b0;
                    state_d    = S_GAP;
                end
            end
            S_GAP: begin
                // One forced low cycle so the next start is a real rising edge.
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Watchdog abort overrides whatever LAUNCH/DRAW decided.
        if (wd_hit) begin
            le_start_d = 1'b0;
            tmo_d      = 1'b1;
            state_d    = S_GAP;
        end
    end

    // State and datapath registers; reset drops le_start immediately.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= S_IDLE;
            cmd_q      <= '0;
            le_start_q <= 1'b0;
            grant_q    <= 1'b0;
            rr_last_q  <= 1'b1;
            pix_q      <= '0;
            tmo_q      <= 1'b0;
            wdog_q     <= '0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            le_start_q <= le_start_d;
            grant_q    <= grant_d;
            rr_last_q  <= rr_last_d;
            pix_q      <= pix_d;
            tmo_q      <= tmo_d;
            wdog_q     <= wdog_d;
        end
    end

endmodule
